rf_operand_fetch: RTL and testbench
===================================

RF_OPERAND_FETCH -- requirements
Module: rf_operand_fetch

Interface
REQ-001 SHALL have parameter BW_DATA, default 16, meaning operand/register data width.
REQ-002 SHALL have parameter BW_ADDR, default 4, meaning register address width (2**BW_ADDR registers).
REQ-003 SHALL use one clock, i_clk; reset is asynchronous and active-low, i_rstn.
REQ-004 SHALL have ports as follows:
- i_clk  in  1  clock, all state updates on rising edge
- i_rstn  in  1  async active-low reset
- i_req_valid  in  1  fetch request valid
- o_req_ready  out  1  block can accept a request
- i_req_addr0  in  BW_ADDR  source register 0 address
- i_req_addr1  in  BW_ADDR  source register 1 address
- o_rf_rd_addr0  out  BW_ADDR  to regfile read port 0
- o_rf_rd_addr1  out  BW_ADDR  to regfile read port 1
- i_rf_rd_data0  in  BW_DATA  regfile read data 0, combinational in the address
- i_rf_rd_data1  in  BW_DATA  regfile read data 1
- i_rf_wr_en  in  1  snoop of regfile write enable
- i_rf_wr_addr  in  BW_ADDR  snoop of regfile write address
- i_rf_wr_data  in  BW_DATA  snoop of regfile write data
- o_opd_valid  out  1  operand pair valid
- i_opd_ready  in  1  consumer accepts operand pair
- o_opd_data0  out  BW_DATA  operand 0
- o_opd_data1  out  BW_DATA  operand 1

Function
REQ-005 SHALL drive o_rf_rd_addr0/1 combinationally equal to i_req_addr0/1.
REQ-006 SHALL accept a request on a rising edge where i_req_valid && o_req_ready, capturing i_rf_rd_data0/1 and both addresses.
REQ-007 SHALL present captured operands on o_opd_* in the cycle after acceptance; latency is exactly 1 cycle when the output is empty.
REQ-008 SHALL transfer an operand pair on an edge where o_opd_valid && i_opd_ready.
REQ-009 SHALL hold a 2-entry buffer (output entry + skid entry) with states EMPTY, ONE, FULL.
REQ-010 SHALL transition: EMPTY→ONE on accept; ONE→EMPTY on transfer without accept; ONE→ONE on accept+transfer; ONE→FULL on accept without transfer; FULL→ONE on transfer (skid moves to output); FULL never accepts.
REQ-011 SHALL drive o_req_ready = 1 in EMPTY and ONE, 0 in FULL, purely from registered state (no combinational path from i_opd_ready).
REQ-012 SHALL keep o_opd_valid, o_opd_data0/1 stable while o_opd_valid && !i_opd_ready, except for forwarding updates per REQ-016.
REQ-013 SHALL preserve request order; no pair dropped or duplicated.
REQ-014 Without forwarding, a pair accepted on an edge where the regfile writes the same address SHALL hold the pre-write (old) value.

Reset
REQ-015 SHALL, while i_rstn low, force state EMPTY, o_opd_valid=0, o_opd_data0/1=0, o_req_ready=0, stored addresses=0; reset mid-transfer discards buffered pairs; o_req_ready rises to 1 in the first cycle after deassertion.

Configuration
REQ-016 With macro RF_OPD_FWD_EN defined, SHALL: (a) on accept, substitute i_rf_wr_data for an operand whose address equals i_rf_wr_addr when i_rf_wr_en=1; (b) on every edge with i_rf_wr_en=1, overwrite any held operand (output or skid entry) whose stored address equals i_rf_wr_addr; both operands of one pair update if both match.
REQ-017 Without RF_OPD_FWD_EN, snoop inputs SHALL be unused and held operands SHALL never change after capture.

Structure
REQ-018 Package rf_pkg SHALL hold default BW_DATA/BW_ADDR constants and the EMPTY/ONE/FULL state encoding.
REQ-019 One sub-module rf_opd_entry SHALL implement a single buffer entry (data, address, load, forward-on-match), instantiated twice.

Verification
REQ-020 Reset, regfile preloaded reg[i]=i; request (3,5), i_opd_ready=1 → next cycle o_opd_valid=1, data0=3, data1=5.
REQ-021 i_opd_ready=0, requests (1,2),(3,4) → FULL, o_req_ready=0; raise ready → pairs (1,2) then (3,4) in order, ready back to 1.
REQ-022 Request (7,7) on an edge writing reg7=0xBEEF → forwarding on: 0xBEEF/0xBEEF; off: 7/7.
REQ-023 Pair (2,9) stalled, then reg9←0x1234 → forwarding on: data1=0x1234, data0=2; off: unchanged.
REQ-024 Assert i_rstn low while FULL → o_opd_valid=0, data=0 immediately; after release o_req_ready=1, no stale pair emitted.
REQ-025 Random valid/ready over all 2**BW_ADDR addresses, 1000 requests → output sequence equals scoreboard model, no loss/duplication.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and buffer-state encoding for the register-file operand fetch block.
package rf_pkg;

  localparam int unsigned BW_DATA_DEF = 16;
  localparam int unsigned BW_ADDR_DEF = 4;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } rf_state_t;

endpackage

// File: rtl/rf_opd_entry.sv
// One operand-pair buffer entry: data plus source addresses, loadable, with optional
// write-snoop forwarding when RF_OPD_FWD_EN is defined.
module rf_opd_entry #(
  parameter int unsigned BW_DATA = 16,
  parameter int unsigned BW_ADDR = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_load,
  input  logic [BW_DATA-1:0] i_data0,
  input  logic [BW_DATA-1:0] i_data1,
  input  logic [BW_ADDR-1:0] i_addr0,
  input  logic [BW_ADDR-1:0] i_addr1,
  input  logic               i_wr_en,
  input  logic [BW_ADDR-1:0] i_wr_addr,
  input  logic [BW_DATA-1:0] i_wr_data,
  output logic [BW_DATA-1:0] o_data0,
  output logic [BW_DATA-1:0] o_data1,
  output logic [BW_ADDR-1:0] o_addr0,
  output logic [BW_ADDR-1:0] o_addr1
);

  logic [BW_DATA-1:0] r_data0, r_data1;
  logic [BW_ADDR-1:0] r_addr0, r_addr1;
  logic [BW_DATA-1:0] w_data0_d, w_data1_d;
  logic [BW_ADDR-1:0] w_addr0_d, w_addr1_d;

  always_comb begin
    w_addr0_d = i_load ? i_addr0 : r_addr0;
    w_addr1_d = i_load ? i_addr1 : r_addr1;
    w_data0_d = i_load ? i_data0 : r_data0;
    w_data1_d = i_load ? i_data1 : r_data1;
`ifdef RF_OPD_FWD_EN
    // Match on the post-load address so freshly loaded and held operands both see the write.
    if (i_wr_en && (w_addr0_d == i_wr_addr)) w_data0_d = i_wr_data;
    if (i_wr_en && (w_addr1_d == i_wr_addr)) w_data1_d = i_wr_data;
`endif
  end

`ifndef RF_OPD_FWD_EN
  logic w_unused_snoop;
  assign w_unused_snoop = ^{i_wr_en, i_wr_addr, i_wr_data};
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_addr0 <= '0;
      r_addr1 <= '0;
    end else begin
      r_data0 <= w_data0_d;
      r_data1 <= w_data1_d;
      r_addr0 <= w_addr0_d;
      r_addr1 <= w_addr1_d;
    end
  end

  assign o_data0 = r_data0;
  assign o_data1 = r_data1;
  assign o_addr0 = r_addr0;
  assign o_addr1 = r_addr1;

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand fetch stage: reads two regfile ports on request and buffers the pair in a 2-entry
// skid buffer. Define RF_OPD_FWD_EN to forward snooped regfile writes into buffered operands.
module rf_operand_fetch
  import rf_pkg::*;
#(
  parameter int unsigned BW_DATA = BW_DATA_DEF,
  parameter int unsigned BW_ADDR = BW_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [BW_ADDR-1:0] i_req_addr0,
  input  logic [BW_ADDR-1:0] i_req_addr1,
  output logic [BW_ADDR-1:0] o_rf_rd_addr0,
  output logic [BW_ADDR-1:0] o_rf_rd_addr1,
  input  logic [BW_DATA-1:0] i_rf_rd_data0,
  input  logic [BW_DATA-1:0] i_rf_rd_data1,
  input  logic               i_rf_wr_en,
  input  logic [BW_ADDR-1:0] i_rf_wr_addr,
  input  logic [BW_DATA-1:0] i_rf_wr_data,
  output logic               o_opd_valid,
  input  logic               i_opd_ready,
  output logic [BW_DATA-1:0] o_opd_data0,
  output logic [BW_DATA-1:0] o_opd_data1
);

  rf_state_t r_state, w_state_d;
  logic      r_req_ready;
  logic      w_accept, w_xfer;
  logic      w_out_load, w_skid_load, w_out_from_skid;

  logic [BW_DATA-1:0] w_out_ld_data0, w_out_ld_data1;
  logic [BW_ADDR-1:0] w_out_ld_addr0, w_out_ld_addr1;
  logic [BW_DATA-1:0] w_skid_data0, w_skid_data1;
  logic [BW_ADDR-1:0] w_skid_addr0, w_skid_addr1;
  logic [BW_ADDR-1:0] w_out_addr0, w_out_addr1;

  assign o_rf_rd_addr0 = i_req_addr0;
  assign o_rf_rd_addr1 = i_req_addr1;

  assign o_req_ready = r_req_ready;
  assign o_opd_valid = (r_state != StEmpty);
  assign w_accept    = i_req_valid && r_req_ready;
  assign w_xfer      = o_opd_valid && i_opd_ready;

  // Ready is registered from next state so it never depends combinationally on i_opd_ready.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= StEmpty;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_req_ready <= (w_state_d != StFull);
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StEmpty: if (w_accept) w_state_d = StOne;
      StOne: begin
        if (w_accept && !w_xfer)      w_state_d = StFull;
        else if (!w_accept && w_xfer) w_state_d = StEmpty;
      end
      StFull:  if (w_xfer) w_state_d = StOne;
      default: w_state_d = StEmpty;
    endcase
  end

  always_comb begin
    w_out_load      = 1'b0;
    w_skid_load     = 1'b0;
    w_out_from_skid = 1'b0;
    unique case (r_state)
      StEmpty: w_out_load = w_accept;
      StOne: begin
        w_out_load  = w_accept && w_xfer;
        w_skid_load = w_accept && !w_xfer;
      end
      StFull: begin
        w_out_load      = w_xfer;
        w_out_from_skid = w_xfer;
      end
      default: ;
    endcase
  end

  assign w_out_ld_data0 = w_out_from_skid ? w_skid_data0 : i_rf_rd_data0;
  assign w_out_ld_data1 = w_out_from_skid ? w_skid_data1 : i_rf_rd_data1;
  assign w_out_ld_addr0 = w_out_from_skid ? w_skid_addr0 : i_req_addr0;
  assign w_out_ld_addr1 = w_out_from_skid ? w_skid_addr1 : i_req_addr1;

  rf_opd_entry #(
    .BW_DATA(BW_DATA),
    .BW_ADDR(BW_ADDR)
  ) u_out_entry (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_load   (w_out_load),
    .i_data0  (w_out_ld_data0),
    .i_data1  (w_out_ld_data1),
    .i_addr0  (w_out_ld_addr0),
    .i_addr1  (w_out_ld_addr1),
    .i_wr_en  (i_rf_wr_en),
    .i_wr_addr(i_rf_wr_addr),
    .i_wr_data(i_rf_wr_data),
    .o_data0  (o_opd_data0),
    .o_data1  (o_opd_data1),
    .o_addr0  (w_out_addr0),
    .o_addr1  (w_out_addr1)
  );

  rf_opd_entry #(
    .BW_DATA(BW_DATA),
    .BW_ADDR(BW_ADDR)
  ) u_skid_entry (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_load   (w_skid_load),
    .i_data0  (i_rf_rd_data0),
    .i_data1  (i_rf_rd_data1),
    .i_addr0  (i_req_addr0),
    .i_addr1  (i_req_addr1),
    .i_wr_en  (i_rf_wr_en),
    .i_wr_addr(i_rf_wr_addr),
    .i_wr_data(i_rf_wr_data),
    .o_data0  (w_skid_data0),
    .o_data1  (w_skid_data1),
    .o_addr0  (w_skid_addr0),
    .o_addr1  (w_skid_addr1)
  );

  logic w_unused_out_addr;
  assign w_unused_out_addr = ^{w_out_addr0, w_out_addr1};

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed and randomized self-checking bench for rf_operand_fetch with a behavioural regfile.
module tb_rf_operand_fetch;

  localparam int BW_DATA = 16;
  localparam int BW_ADDR = 4;

  logic               clk = 1'b0;
  logic               rstn;
  logic               req_valid;
  logic               req_ready;
  logic [BW_ADDR-1:0] req_addr0, req_addr1;
  logic [BW_ADDR-1:0] rd_addr0, rd_addr1;
  logic [BW_DATA-1:0] rd_data0, rd_data1;
  logic               wr_en;
  logic [BW_ADDR-1:0] wr_addr;
  logic [BW_DATA-1:0] wr_data;
  logic               opd_valid;
  logic               opd_ready;
  logic [BW_DATA-1:0] opd_data0, opd_data1;

  logic [BW_DATA-1:0] regs [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];

  rf_operand_fetch #(
    .BW_DATA(BW_DATA),
    .BW_ADDR(BW_ADDR)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr0  (req_addr0),
    .i_req_addr1  (req_addr1),
    .o_rf_rd_addr0(rd_addr0),
    .o_rf_rd_addr1(rd_addr1),
    .i_rf_rd_data0(rd_data0),
    .i_rf_rd_data1(rd_data1),
    .i_rf_wr_en   (wr_en),
    .i_rf_wr_addr (wr_addr),
    .i_rf_wr_data (wr_data),
    .o_opd_valid  (opd_valid),
    .i_opd_ready  (opd_ready),
    .o_opd_data0  (opd_data0),
    .o_opd_data1  (opd_data1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    chk("reset_valid", 32'(opd_valid), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_data0", 32'(opd_data0), 32'd0);
    chk("reset_data1", 32'(opd_data1), 32'd0);
    rstn = 1'b1;
    tick();
    chk("release_ready", 32'(req_ready), 32'd1);
    chk("release_valid", 32'(opd_valid), 32'd0);
  endtask

  task automatic test_basic();
    opd_ready = 1'b1;
    req_valid = 1'b1;
    req_addr0 = 4'd3;
    req_addr1 = 4'd5;
    #1;
    chk("rd_addr0", 32'(rd_addr0), 32'd3);
    chk("rd_addr1", 32'(rd_addr1), 32'd5);
    tick();
    req_valid = 1'b0;
    chk("basic_valid", 32'(opd_valid), 32'd1);
    chk("basic_data0", 32'(opd_data0), 32'd3);
    chk("basic_data1", 32'(opd_data1), 32'd5);
    tick();
    chk("basic_drained", 32'(opd_valid), 32'd0);
  endtask

  task automatic test_full();
    opd_ready = 1'b0;
    req_valid = 1'b1;
    req_addr0 = 4'd1;
    req_addr1 = 4'd2;
    tick();
    req_addr0 = 4'd3;
    req_addr1 = 4'd4;
    tick();
    req_valid = 1'b0;
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_valid", 32'(opd_valid), 32'd1);
    tick();
    chk("full_hold0", 32'(opd_data0), 32'd1);
    chk("full_hold1", 32'(opd_data1), 32'd2);
    opd_ready = 1'b1;
    tick();
    chk("full_second0", 32'(opd_data0), 32'd3);
    chk("full_second1", 32'(opd_data1), 32'd4);
    chk("full_second_valid", 32'(opd_valid), 32'd1);
    chk("full_ready_back", 32'(req_ready), 32'd1);
    tick();
    chk("full_drained", 32'(opd_valid), 32'd0);
  endtask

  task automatic test_same_edge_write();
    opd_ready = 1'b0;
    req_valid = 1'b1;
    req_addr0 = 4'd7;
    req_addr1 = 4'd7;
    wr_en     = 1'b1;
    wr_addr   = 4'd7;
    wr_data   = 16'hBEEF;
    tick();
    regs[7]   = 16'hBEEF;
    req_valid = 1'b0;
    wr_en     = 1'b0;
`ifdef RF_OPD_FWD_EN
    chk("sameedge_data0", 32'(opd_data0), 32'hBEEF);
    chk("sameedge_data1", 32'(opd_data1), 32'hBEEF);
`else
    chk("sameedge_data0", 32'(opd_data0), 32'd7);
    chk("sameedge_data1", 32'(opd_data1), 32'd7);
`endif
    opd_ready = 1'b1;
    tick();
    chk("sameedge_drained", 32'(opd_valid), 32'd0);
  endtask

  task automatic test_stall_fwd();
    opd_ready = 1'b0;
    req_valid = 1'b1;
    req_addr0 = 4'd2;
    req_addr1 = 4'd9;
    tick();
    req_valid = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 4'd9;
    wr_data   = 16'h1234;
    tick();
    regs[9] = 16'h1234;
    wr_en   = 1'b0;
    chk("stall_data0", 32'(opd_data0), 32'd2);
`ifdef RF_OPD_FWD_EN
    chk("stall_data1", 32'(opd_data1), 32'h1234);
`else
    chk("stall_data1", 32'(opd_data1), 32'd9);
`endif
    opd_ready = 1'b1;
    tick();
    chk("stall_drained", 32'(opd_valid), 32'd0);
  endtask

  task automatic test_reset_full();
    opd_ready = 1'b0;
    req_valid = 1'b1;
    req_addr0 = 4'd1;
    req_addr1 = 4'd2;
    tick();
    req_addr0 = 4'd3;
    req_addr1 = 4'd4;
    tick();
    req_valid = 1'b0;
    chk("rstfull_ready", 32'(req_ready), 32'd0);
    rstn = 1'b0;
    #1;
    chk("rstfull_valid", 32'(opd_valid), 32'd0);
    chk("rstfull_data0", 32'(opd_data0), 32'd0);
    chk("rstfull_data1", 32'(opd_data1), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("rstfull_ready_after", 32'(req_ready), 32'd1);
    opd_ready = 1'b1;
    repeat (3) tick();
    chk("rstfull_no_stale", 32'(opd_valid), 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp;
    int sent = 0;
    int cyc = 0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      req_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      req_addr0 = BW_ADDR'($urandom_range(0, 15));
      req_addr1 = BW_ADDR'($urandom_range(0, 15));
      opd_ready = ($urandom_range(0, 2) != 0);
      if (opd_valid && opd_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_dup: got %0h%0h expected nothing", opd_data0, opd_data1);
        end else begin
          exp = q.pop_front();
          chk("rand_pair", {opd_data0, opd_data1}, exp);
        end
      end
      if (req_valid && req_ready) begin
        q.push_back({regs[req_addr0], regs[req_addr1]});
        sent++;
      end
      tick();
      cyc++;
    end
    req_valid = 1'b0;
    chk("rand_sent", 32'(sent), 32'd1000);
    chk("rand_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = BW_DATA'(i);
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_addr0 = '0;
    req_addr1 = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    opd_ready = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_full();
    test_same_edge_write();
    test_stall_fwd();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
